// File: rtl/tx_frame_fifo_pkg.sv
// Shared constants and pointer arithmetic for the TX frame FIFO.
package tx_frame_fifo_pkg;

    localparam int unsigned OVF_CNT_W = 16;

    // Modular pointer difference; pointers wrap at 2**bits.
    function automatic logic [31:0] ptr_diff(logic [31:0] a, logic [31:0] b, int unsigned bits);
        logic [31:0] mask;
        mask = (32'd1 << bits) - 32'd1;
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/tx_frame_fifo_if.sv
// Producer/consumer bus of the TX frame FIFO; master drives writes and rd_ready.
interface tx_frame_fifo_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 256
);
    localparam int unsigned ADDR_BITS = $clog2(DEPTH);

    logic                 wr_en;
    logic [WIDTH-1:0]     wr_data;
    logic                 wr_commit;
    logic                 wr_abort;
    logic                 full;
    logic                 almost_full;
    logic [ADDR_BITS:0]   free;
    logic                 wr_overflow;
    logic                 rd_valid;
    logic [WIDTH-1:0]     rd_data;
    logic                 rd_ready;
    logic [ADDR_BITS:0]   rd_level;

    modport master (
        output wr_en, wr_data, wr_commit, wr_abort, rd_ready,
        input  full, almost_full, free, wr_overflow, rd_valid, rd_data, rd_level
    );

    modport slave (
        input  wr_en, wr_data, wr_commit, wr_abort, rd_ready,
        output full, almost_full, free, wr_overflow, rd_valid, rd_data, rd_level
    );

endinterface

// File: rtl/tx_frame_fifo_dpram.sv
// Storage for the TX frame FIFO: one synchronous write port, one asynchronous read port.
module fifo_dpram #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 256
) (
    input  logic                       clk,
    input  logic                       i_we,
    input  logic [$clog2(DEPTH)-1:0]   i_waddr,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic [$clog2(DEPTH)-1:0]   i_raddr,
    output logic [WIDTH-1:0]           o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/tx_frame_fifo.sv
// TX FIFO with speculative writes and frame commit/abort; reader only sees committed words.
// Optional frame/overflow statistics enabled by defining TX_FRAME_FIFO_STATS_EN.
module tx_frame_fifo
    import tx_frame_fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned AF_THRESH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    tx_frame_fifo_if.slave            bus
`ifdef TX_FRAME_FIFO_STATS_EN
    ,
    output logic [$clog2(DEPTH):0]    o_frames_pending,
    output logic [OVF_CNT_W-1:0]      o_ovf_count
`endif
);

    localparam int unsigned ADDR_BITS = $clog2(DEPTH);
    localparam int unsigned PTR_W     = ADDR_BITS + 1;

    typedef logic [ADDR_BITS:0] ptr_t;

    ptr_t             r_wr_ptr, r_cm_ptr, r_rd_ptr;
    logic             r_ovf;
    ptr_t             w_used, w_level, w_free, w_wr_ptr_next;
    logic             w_full, w_wr_go, w_rd_go, w_ovf_evt, w_rd_valid;
    logic [WIDTH-1:0] w_mem_rdata;

    assign w_used        = ptr_t'(ptr_diff(32'(r_wr_ptr), 32'(r_rd_ptr), PTR_W));
    assign w_level       = ptr_t'(ptr_diff(32'(r_cm_ptr), 32'(r_rd_ptr), PTR_W));
    assign w_free        = ptr_t'(DEPTH) - w_used;
    assign w_full        = (w_used == ptr_t'(DEPTH));
    assign w_rd_valid    = (r_rd_ptr != r_cm_ptr);
    // Abort discards this cycle's word too, so it never reaches memory.
    assign w_wr_go       = bus.wr_en & ~w_full & ~bus.wr_abort;
    assign w_ovf_evt     = bus.wr_en & w_full;
    assign w_wr_ptr_next = r_wr_ptr + ptr_t'(w_wr_go);
    assign w_rd_go       = w_rd_valid & bus.rd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_cm_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_wr_ptr <= bus.wr_abort ? r_cm_ptr : w_wr_ptr_next;
            if (bus.wr_commit && !bus.wr_abort) begin
                r_cm_ptr <= w_wr_ptr_next;
            end
            if (w_rd_go) begin
                r_rd_ptr <= r_rd_ptr + ptr_t'(1);
            end
            r_ovf <= w_ovf_evt;
        end
    end

    fifo_dpram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_go),
        .i_waddr (r_wr_ptr[ADDR_BITS-1:0]),
        .i_wdata (bus.wr_data),
        .i_raddr (r_rd_ptr[ADDR_BITS-1:0]),
        .o_rdata (w_mem_rdata)
    );

    assign bus.full        = w_full;
    assign bus.almost_full = (32'(w_free) <= AF_THRESH);
    assign bus.free        = w_free;
    assign bus.wr_overflow = r_ovf;
    assign bus.rd_valid    = w_rd_valid;
    assign bus.rd_data     = w_rd_valid ? w_mem_rdata : '0;
    assign bus.rd_level    = w_level;

`ifdef TX_FRAME_FIFO_STATS_EN
    // End-of-frame marker per slot; a frame is drained when its marked word is read.
    logic [DEPTH-1:0]       r_eof;
    ptr_t                   r_frames;
    logic [OVF_CNT_W-1:0]   r_ovf_cnt;
    logic                   w_new_frame, w_frame_done;
    logic [ADDR_BITS-1:0]   w_last_idx;

    assign w_new_frame  = bus.wr_commit & ~bus.wr_abort & (w_wr_ptr_next != r_cm_ptr);
    assign w_frame_done = w_rd_go & r_eof[r_rd_ptr[ADDR_BITS-1:0]];
    assign w_last_idx   = r_wr_ptr[ADDR_BITS-1:0] - ADDR_BITS'(1);

    always_ff @(posedge clk) begin
        if (w_wr_go) begin
            r_eof[r_wr_ptr[ADDR_BITS-1:0]] <= bus.wr_commit;
        end else if (w_new_frame) begin
            r_eof[w_last_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frames  <= '0;
            r_ovf_cnt <= '0;
        end else begin
            if (w_new_frame && !w_frame_done && r_frames != ptr_t'(DEPTH)) begin
                r_frames <= r_frames + ptr_t'(1);
            end else if (!w_new_frame && w_frame_done) begin
                r_frames <= r_frames - ptr_t'(1);
            end
            if (w_ovf_evt && r_ovf_cnt != '1) begin
                r_ovf_cnt <= r_ovf_cnt + OVF_CNT_W'(1);
            end
        end
    end

    assign o_frames_pending = r_frames;
    assign o_ovf_count      = r_ovf_cnt;
`endif

endmodule
